// File: rtl/result_drain_ctrl.sv
// Drains the n x n result matrix from the multiplier result buffer onto a valid/ready stream.
// Optional column-major (transposed) drain order when DRAIN_TRANSPOSE_EN is defined.
module result_drain_ctrl #(
   parameter int n      = 8,
   parameter int n_len  = $clog2(n),
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     rd_en,
   output logic [2*(n_len+1)-1:0]   rd_addr,
   input  logic [DATA_W-1:0]        rd_data,
   output logic [n_len:0]           i,
   output logic [n_len:0]           j,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done
);

   localparam int IW = n_len + 1;
   localparam int AW = 2 * IW;
   localparam logic [IW-1:0] last_idx = IW'(n - 1);

   typedef enum logic [1:0] {
      s_idle,
      s_run,
      s_flush,
      s_done
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [IW-1:0]     ri;
   logic [IW-1:0]     rj;
   logic [IW-1:0]     hi;
   logic [IW-1:0]     hj;
   logic              inflight;
   logic [DATA_W-1:0] mem [2];
   logic              wptr;
   logic              rptr;
   logic [1:0]        occ;
   logic              push;
   logic              pop;
   logic [2:0]        load;
   logic              issue_last;
   logic              head_last;
   logic              accept;

   // Advance a (row, col) pair in drain order; the final element wraps back to (0, 0).
   function automatic logic [2*IW-1:0] next_rc(input logic [IW-1:0] r, input logic [IW-1:0] c);
      logic [2*IW-1:0] res;
      if (r == last_idx && c == last_idx) begin
         res = '0;
      end
`ifdef DRAIN_TRANSPOSE_EN
      else if (r == last_idx) begin
         res = {{IW{1'b0}}, c + 1'b1};
      end else begin
         res = {r + 1'b1, c};
      end
`else
      else if (c == last_idx) begin
         res = {r + 1'b1, {IW{1'b0}}};
      end else begin
         res = {r, c + 1'b1};
      end
`endif
      return res;
   endfunction

   assign push       = inflight;
   assign pop        = out_valid & out_ready;
   assign out_valid  = (occ != 2'd0);
   assign out_data   = out_valid ? mem[rptr] : '0;
   assign issue_last = (ri == last_idx) && (rj == last_idx);
   assign head_last  = (hi == last_idx) && (hj == last_idx);
   assign out_last   = out_valid & head_last;
   assign i          = hi;
   assign j          = hj;
   assign accept     = (state == s_idle) && start;
   assign rd_addr    = AW'(ri) * AW'(n) + AW'(rj);

   // Elements that will be held (buffered or returning) after this cycle, before any new read.
   assign load = 3'(occ) + 3'(inflight) - 3'(pop);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= s_idle;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control outputs; reads are throttled so the 2-entry buffer can never overflow.
   always_comb begin
      state_next = state;
      rd_en      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         s_idle: begin
            if (start) begin
               state_next = s_run;
            end
         end
         s_run: begin
            busy = 1'b1;
            if (load < 3'd2 && !rst) begin
               rd_en = 1'b1;
               if (issue_last) begin
                  state_next = s_flush;
               end
            end
         end
         s_flush: begin
            busy = 1'b1;
            if (load == 3'd0) begin
               state_next = s_done;
            end
         end
         s_done: begin
            done       = 1'b1;
            state_next = s_idle;
         end
         default: begin
            state_next = s_idle;
         end
      endcase
   end

   // Read-side index walker.
   always_ff @(posedge clk) begin
      if (rst) begin
         ri <= '0;
         rj <= '0;
      end else if (accept) begin
         ri <= '0;
         rj <= '0;
      end else if (rd_en) begin
         {ri, rj} <= next_rc(ri, rj);
      end
   end

   // A return is only accepted for a read issued since the last reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= 1'b0;
      end else begin
         inflight <= rd_en;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ  <= 2'd0;
         wptr <= 1'b0;
         rptr <= 1'b0;
      end else begin
         occ <= 2'(3'(occ) + 3'(push) - 3'(pop));
         if (push) begin
            wptr <= ~wptr;
         end
         if (pop) begin
            rptr <= ~rptr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= rd_data;
      end
   end

   // Head tags follow the same walk order as the reads, one step per accepted element.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi <= '0;
         hj <= '0;
      end else if (accept) begin
         hi <= '0;
         hj <= '0;
      end else if (pop) begin
         {hi, hj} <= next_rc(hi, hj);
      end
   end

endmodule
